// File: rtl/ysyx_220053_ifu_prefetch.sv
// Instruction fetch unit with an in-order prefetch queue between a valid/ready memory port
// and decode, including redirect flush that discards responses belonging to squashed fetches.

module ysyx_220053_ifu_prefetch_chk #(
    parameter int PW    = 2,
    parameter int DEPTH = 4
) (
    input logic          clk,
    input logic          rst,
    input logic          rsp_valid,
    input logic [PW:0]   drop,
    input logic [PW:0]   pending,
    input logic [PW+1:0] occ
);
    localparam logic [PW:0]   PTR_ZERO = {(PW+1){1'b0}};
    localparam logic [PW+1:0] DEPTH_W  = DEPTH[PW+1:0];

    // Every response must belong to a squashed fetch or to a pending queue entry.
    rsp_has_owner: assert property (@(posedge clk) disable iff (!rst)
        rsp_valid |-> ((drop != PTR_ZERO) || (pending != PTR_ZERO)));

    occ_bounded: assert property (@(posedge clk) disable iff (!rst) occ <= DEPTH_W);
endmodule

module ysyx_220053_ifu_prefetch #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = 64'h0000_0000_8000_0000,
    parameter int              DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst,
    output logic            req_valid,
    input  logic            req_ready,
    output logic [XLEN-1:0] req_addr,
    input  logic            rsp_valid,
    input  logic [63:0]     rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr_pc,
    output logic [31:0]     instr_o
);
    localparam int            PW       = $clog2(DEPTH);
    localparam logic [PW:0]   PTR_ZERO = {(PW+1){1'b0}};
    localparam logic [PW:0]   PTR_ONE  = {{PW{1'b0}}, 1'b1};
    localparam logic [PW+1:0] DEPTH_W  = DEPTH[PW+1:0];

    logic            run_r;
    logic [XLEN-1:0] fetch_pc_r;
    logic [PW:0]     head_r, fill_r, tail_r, drop_r;
    logic [XLEN-1:0] pc_q_r [DEPTH];
    logic [31:0]     instr_q_r [DEPTH];
    logic [DEPTH-1:0] filled_r;

    logic [PW:0]     count_s, pending_s, redir_drop_s;
    logic [PW+1:0]   occ_s;
    logic            issue_s, rsp_drop_s, rsp_fill_s, deq_s;
    logic [31:0]     rsp_word_s;

    // Occupancy, handshakes and redirect drop accounting, all from current state.
    always_comb begin
        count_s     = tail_r - head_r;
        pending_s   = tail_r - fill_r;
        occ_s       = {1'b0, count_s} + {1'b0, drop_r};
        req_valid   = run_r && !redirect_valid && (occ_s < DEPTH_W);
        issue_s     = req_valid && req_ready;
        rsp_drop_s  = rsp_valid && (drop_r != PTR_ZERO);
        rsp_fill_s  = rsp_valid && (drop_r == PTR_ZERO) && (pending_s != PTR_ZERO);
        instr_valid = (count_s != PTR_ZERO) && filled_r[head_r[PW-1:0]];
        deq_s       = instr_valid && instr_ready;
        // The response arriving with a redirect is always discarded, so it retires one owner.
        if (rsp_drop_s || rsp_fill_s) begin
            redir_drop_s = drop_r + pending_s - PTR_ONE;
        end else begin
            redir_drop_s = drop_r + pending_s;
        end
        if (pc_q_r[fill_r[PW-1:0]][2]) begin
            rsp_word_s = rsp_data[63:32];
        end else begin
            rsp_word_s = rsp_data[31:0];
        end
    end

    assign req_addr = {fetch_pc_r[XLEN-1:3], fetch_pc_r[2:0] & 3'b000};
    assign instr_pc = pc_q_r[head_r[PW-1:0]];
    assign instr_o  = instr_q_r[head_r[PW-1:0]];

    // Control state: fetch PC, queue pointers and count of responses still to discard.
    always_ff @(posedge clk) begin
        if (!rst) begin
            run_r      <= 1'b0;
            fetch_pc_r <= RESET_PC;
            head_r     <= PTR_ZERO;
            fill_r     <= PTR_ZERO;
            tail_r     <= PTR_ZERO;
            drop_r     <= PTR_ZERO;
        end else begin
            run_r <= 1'b1;
            if (redirect_valid) begin
                fetch_pc_r <= {redirect_pc[XLEN-1:2], redirect_pc[1:0] & 2'b00};
                head_r     <= PTR_ZERO;
                fill_r     <= PTR_ZERO;
                tail_r     <= PTR_ZERO;
                drop_r     <= redir_drop_s;
            end else begin
                if (issue_s) begin
                    tail_r     <= tail_r + PTR_ONE;
                    fetch_pc_r <= fetch_pc_r + XLEN'(4);
                end
                if (rsp_drop_s) begin
                    drop_r <= drop_r - PTR_ONE;
                end
                if (rsp_fill_s) begin
                    fill_r <= fill_r + PTR_ONE;
                end
                if (deq_s) begin
                    head_r <= head_r + PTR_ONE;
                end
            end
        end
    end

    // Entry filled flags: cleared when the fetch issues, set when its response lands.
    always_ff @(posedge clk) begin
        if (!rst) begin
            filled_r <= {DEPTH{1'b0}};
        end else begin
            if (issue_s) begin
                filled_r[tail_r[PW-1:0]] <= 1'b0;
            end
            if (rsp_fill_s && !redirect_valid) begin
                filled_r[fill_r[PW-1:0]] <= 1'b1;
            end
        end
    end

    // Entry payload; left unreset because the filled flags gate every use.
    always_ff @(posedge clk) begin
        if (issue_s) begin
            pc_q_r[tail_r[PW-1:0]] <= fetch_pc_r;
        end
        if (rsp_fill_s && !redirect_valid) begin
            instr_q_r[fill_r[PW-1:0]] <= rsp_word_s;
        end
    end

    ysyx_220053_ifu_prefetch_chk #(
        .PW    (PW),
        .DEPTH (DEPTH)
    ) u_chk (
        .clk       (clk),
        .rst       (rst),
        .rsp_valid (rsp_valid),
        .drop      (drop_r),
        .pending   (pending_s),
        .occ       (occ_s)
    );
endmodule

// File: tb/tb_ysyx_220053_ifu_prefetch.sv
// Directed bench for the prefetching fetch unit: a latency-configurable in-order memory model
// feeds responses, and delivered instructions are logged and checked against expected PCs.
`timescale 1ns/1ps

module tb_ysyx_220053_ifu_prefetch;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_addr;
    logic        rsp_valid;
    logic [63:0] rsp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [63:0] instr_pc;
    logic [31:0] instr_o;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int lat   = 1;

    logic [63:0] mem_addr_q[$];
    int          mem_due_q[$];
    logic [63:0] got_pc_q[$];
    logic [31:0] got_ins_q[$];
    logic [63:0] req_log_q[$];

    always #5 clk = ~clk;

    ysyx_220053_ifu_prefetch dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr       (req_addr),
        .rsp_valid      (rsp_valid),
        .rsp_data       (rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_pc       (instr_pc),
        .instr_o        (instr_o)
    );

    function automatic logic [31:0] word_at(input logic [63:0] a);
        return a[31:0] ^ 32'hDEAD_0013;
    endfunction

    function automatic logic [63:0] got_pc(input int i);
        return (i < got_pc_q.size()) ? got_pc_q[i] : 64'hFFFF_FFFF_FFFF_FFFF;
    endfunction

    function automatic logic [63:0] got_ins(input int i);
        return (i < got_ins_q.size()) ? {32'd0, got_ins_q[i]} : 64'hFFFF_FFFF_FFFF_FFFF;
    endfunction

    function automatic logic [63:0] req_at(input int i);
        return (i < req_log_q.size()) ? req_log_q[i] : 64'hFFFF_FFFF_FFFF_FFFF;
    endfunction

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        got_pc_q.delete();
        got_ins_q.delete();
        req_log_q.delete();
    endtask

    // One clock: sample handshakes mid-cycle, then advance the memory model after the edge.
    task automatic tick();
        logic        acc;
        logic [63:0] acc_addr;
        logic        rst_s;
        @(negedge clk);
        rst_s    = rst;
        acc      = req_valid && req_ready && rst_s;
        acc_addr = req_addr;
        if (acc) req_log_q.push_back(req_addr);
        if (instr_valid && instr_ready && rst_s) begin
            got_pc_q.push_back(instr_pc);
            got_ins_q.push_back(instr_o);
        end
        @(posedge clk);
        #1;
        cyc++;
        rsp_valid = 1'b0;
        rsp_data  = 64'd0;
        if (!rst_s) begin
            mem_addr_q.delete();
            mem_due_q.delete();
        end else begin
            if (acc) begin
                mem_addr_q.push_back(acc_addr);
                mem_due_q.push_back(cyc - 1 + lat);
            end
            if (mem_addr_q.size() > 0 && mem_due_q[0] <= cyc) begin
                rsp_valid = 1'b1;
                rsp_data  = {word_at(mem_addr_q[0] + 64'd4), word_at(mem_addr_q[0])};
                void'(mem_addr_q.pop_front());
                void'(mem_due_q.pop_front());
            end
        end
    endtask

    task automatic do_reset();
        rst            = 1'b0;
        req_ready      = 1'b0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 64'd0;
        tick();
        tick();
        check_val("rst_req_valid", 64'(req_valid), 64'd0);
        check_val("rst_instr_valid", 64'(instr_valid), 64'd0);
        rst = 1'b1;
        #1;
        check_val("rel_req_valid", 64'(req_valid), 64'd0);
        check_val("rel_instr_valid", 64'(instr_valid), 64'd0);
        clear_logs();
    endtask

    initial begin
        int hits;
        rst            = 1'b0;
        req_ready      = 1'b0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 64'd0;
        rsp_valid      = 1'b0;
        rsp_data       = 64'd0;

        // Streaming with a 1-cycle memory.
        do_reset();
        lat = 1; req_ready = 1'b1; instr_ready = 1'b1;
        tick();
        tick();
        check_val("t1_rsp_cycle_no_instr", 64'(instr_valid), 64'd0);
        tick();
        check_val("t1_instr_next_cycle", 64'(instr_valid), 64'd1);
        check_val("t1_first_pc", instr_pc, 64'h8000_0000);
        repeat (8) tick();
        check_val("t1_req0", req_at(0), 64'h8000_0000);
        check_val("t1_req1", req_at(1), 64'h8000_0000);
        check_val("t1_req2", req_at(2), 64'h8000_0008);
        for (int i = 0; i < 4; i++) begin
            check_val("t1_pc", got_pc(i), 64'h8000_0000 + 64'(4 * i));
            check_val("t1_instr", got_ins(i), {32'd0, word_at(64'h8000_0000 + 64'(4 * i))});
        end

        // Decode stalled: queue fills to 4, then drains in order.
        do_reset();
        lat = 1; req_ready = 1'b1; instr_ready = 1'b0;
        repeat (10) tick();
        check_val("t2_req_count", 64'(req_log_q.size()), 64'd4);
        check_val("t2_full_no_req", 64'(req_valid), 64'd0);
        check_val("t2_head_valid", 64'(instr_valid), 64'd1);
        check_val("t2_head_pc", instr_pc, 64'h8000_0000);
        instr_ready = 1'b1;
        #1;
        check_val("t2_full_consume_no_req", 64'(req_valid), 64'd0);
        repeat (12) tick();
        for (int i = 0; i < 5; i++) begin
            check_val("t2_drain_pc", got_pc(i), 64'h8000_0000 + 64'(4 * i));
        end
        check_val("t2_resume_req", req_at(4), 64'h8000_0010);

        // Redirect with three fetches in flight (3-cycle memory).
        do_reset();
        lat = 3; req_ready = 1'b1; instr_ready = 1'b1;
        repeat (4) tick();
        check_val("t3_outstanding", 64'(req_log_q.size()), 64'd3);
        redirect_valid = 1'b1; redirect_pc = 64'h8000_1006;
        #1;
        check_val("t3_redirect_blocks_req", 64'(req_valid), 64'd0);
        tick();
        redirect_valid = 1'b0;
        #1;
        check_val("t3_new_req_valid", 64'(req_valid), 64'd1);
        check_val("t3_new_req_addr", req_addr, 64'h8000_1000);
        repeat (15) tick();
        check_val("t3_first_pc", got_pc(0), 64'h8000_1004);
        check_val("t3_first_instr_high", got_ins(0), {32'd0, word_at(64'h8000_1004)});
        check_val("t3_second_pc", got_pc(1), 64'h8000_1008);

        // Redirect coinciding with a response and a decode handshake.
        do_reset();
        lat = 1; req_ready = 1'b1; instr_ready = 1'b1;
        repeat (5) tick();
        check_val("t4_head_pc", instr_pc, 64'h8000_0008);
        redirect_valid = 1'b1; redirect_pc = 64'h8000_4000;
        tick();
        redirect_valid = 1'b0;
        #1;
        check_val("t4_req_addr", req_addr, 64'h8000_4000);
        check_val("t4_flushed", 64'(instr_valid), 64'd0);
        repeat (10) tick();
        check_val("t4_last_old_pc", got_pc(2), 64'h8000_0008);
        check_val("t4_new_pc", got_pc(3), 64'h8000_4000);
        check_val("t4_new_instr", got_ins(3), {32'd0, word_at(64'h8000_4000)});
        check_val("t4_next_pc", got_pc(4), 64'h8000_4004);

        // Back-to-back redirects.
        do_reset();
        lat = 3; req_ready = 1'b1; instr_ready = 1'b1;
        repeat (5) tick();
        redirect_valid = 1'b1; redirect_pc = 64'h8000_2000;
        tick();
        redirect_pc = 64'h8000_3000;
        tick();
        redirect_valid = 1'b0;
        #1;
        check_val("t5_req_valid", 64'(req_valid), 64'd1);
        check_val("t5_req_addr", req_addr, 64'h8000_3000);
        repeat (20) tick();
        check_val("t5_pre_pc", got_pc(0), 64'h8000_0000);
        check_val("t5_first_pc", got_pc(1), 64'h8000_3000);
        check_val("t5_first_instr", got_ins(1), {32'd0, word_at(64'h8000_3000)});
        check_val("t5_second_pc", got_pc(2), 64'h8000_3004);
        hits = 0;
        foreach (got_pc_q[i]) begin
            if (got_pc_q[i][63:12] == 52'h80002) hits++;
        end
        check_val("t5_no_first_target", 64'(hits), 64'd0);

        // Reset mid-stream with responses outstanding.
        do_reset();
        lat = 3; req_ready = 1'b1; instr_ready = 1'b1;
        repeat (5) tick();
        rst = 1'b0;
        tick();
        check_val("t6_rst_req_valid", 64'(req_valid), 64'd0);
        check_val("t6_rst_instr_valid", 64'(instr_valid), 64'd0);
        rst = 1'b1;
        #1;
        check_val("t6_first_cycle_req", 64'(req_valid), 64'd0);
        clear_logs();
        tick();
        check_val("t6_restart_valid", 64'(req_valid), 64'd1);
        check_val("t6_restart_addr", req_addr, 64'h8000_0000);
        repeat (12) tick();
        check_val("t6_pc0", got_pc(0), 64'h8000_0000);
        check_val("t6_instr0", got_ins(0), {32'd0, word_at(64'h8000_0000)});
        check_val("t6_pc1", got_pc(1), 64'h8000_0004);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
